bicubic_upsample_mc: RTL

BICUBIC_UPSAMPLE_MC -- requirements
Module: bicubic_upsample_mc

---
 rtl/bicubic_upsample_mc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bicubic_upsample_mc.sv
// bicubic_upsample_mc: 4x bicubic upsampler. Each accepted 4x4 source window
// (per colour channel) produces 16 output pixels at sub-positions n=4i+j,
// streamed one per response handshake with registered outputs.
// Optional build macro: BICUBIC_ROUND_EN selects round-half-up instead of
// floor before the final clamp.

// Per-channel filter: separable 4-tap vertical pass, then 4-tap horizontal
// pass, scale down by 2^14 and clamp to the sample range.
module bicubic_upsample_mc_lane #(
    parameter int CW = 8
) (
    input  logic [16*CW-1:0] win_i,
    input  logic [3:0]       pos_i,
    output logic [CW-1:0]    pix_o
);
    localparam int CSW = CW + 9;
    localparam int ACW = CW + 17;
    localparam logic signed [ACW-1:0] MAXV = ACW'((1 << CW) - 1);

    // Phase weights in 1/128 units; phase 0 is the pass-through tap.
    function automatic logic signed [8:0] tap_w(input logic [1:0] ph, input logic [1:0] t);
        logic signed [8:0] w;
        case ({ph, t})
            4'b00_01: w = 9'sd128;
            4'b01_00: w = -9'sd9;
            4'b01_01: w = 9'sd111;
            4'b01_10: w = 9'sd29;
            4'b01_11: w = -9'sd3;
            4'b10_00: w = -9'sd8;
            4'b10_01: w = 9'sd72;
            4'b10_10: w = 9'sd72;
            4'b10_11: w = -9'sd8;
            4'b11_00: w = -9'sd3;
            4'b11_01: w = 9'sd29;
            4'b11_10: w = 9'sd111;
            4'b11_11: w = -9'sd9;
            default:  w = 9'sd0;
        endcase
        return w;
    endfunction

    logic signed [CSW-1:0] col_sum [4];
    logic signed [ACW-1:0] acc;
    logic signed [ACW-1:0] acc_r;
    logic signed [ACW-1:0] shf;

    // Vertical then horizontal weighted sums; widths are sized so neither overflows.
    always_comb begin
        acc = '0;
        for (int c = 0; c < 4; c++) begin
            col_sum[c] = '0;
            for (int r = 0; r < 4; r++) begin
                col_sum[c] = col_sum[c]
                           + CSW'(tap_w(pos_i[3:2], 2'(r)))
                           * CSW'($signed({1'b0, win_i[(4*r+c)*CW +: CW]}));
            end
            acc = acc + ACW'(tap_w(pos_i[1:0], 2'(c))) * ACW'(col_sum[c]);
        end
    end

    // Scale by 2^-14 (optionally rounded) and clamp into [0, 2^CW-1].
    always_comb begin
`ifdef BICUBIC_ROUND_EN
        acc_r = acc + ACW'(8192);
`else
        acc_r = acc;
`endif
        shf = acc_r >>> 14;
        if (shf < 0)
            pix_o = '0;
        else if (shf > MAXV)
            pix_o = '1;
        else
            pix_o = shf[CW-1:0];
    end
endmodule

module bicubic_upsample_mc #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int CH_NUM        = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              bf_req_valid,
    output logic                              bcci_req_ready,
    input  logic [CH_NUM*16*CHANNEL_WIDTH-1:0] bf_req_data,
    output logic                              bcci_rsp_valid,
    input  logic                              bf_rsp_ready,
    output logic [CH_NUM*CHANNEL_WIDTH-1:0]   bcci_rsp_data,
    output logic [3:0]                        bcci_rsp_pos,
    output logic                              bcci_rsp_last
);
    localparam int CW    = CHANNEL_WIDTH;
    localparam int WIN_W = CH_NUM * 16 * CW;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OUT  = 1'b1;

    logic                   state_q;
    logic [WIN_W-1:0]       win_q;
    logic [3:0]             pos_q;
    logic                   last_q;
    logic [CH_NUM*CW-1:0]   data_q;

    logic                   req_hs;
    logic                   rsp_hs;
    logic [WIN_W-1:0]       src_win;
    logic [3:0]             nxt_pos;
    logic [CH_NUM*CW-1:0]   nxt_pix;

    assign bcci_rsp_valid = (state_q == ST_OUT);
    assign bcci_rsp_pos   = pos_q;
    assign bcci_rsp_last  = last_q;
    assign bcci_rsp_data  = data_q;

    // Accept a new window when idle or when the final pixel of the current one leaves.
    assign bcci_req_ready = (state_q == ST_IDLE) | (bcci_rsp_valid & last_q & bf_rsp_ready);
    assign req_hs         = bf_req_valid & bcci_req_ready;
    assign rsp_hs         = bcci_rsp_valid & bf_rsp_ready;

    // The pixel about to be registered: n=0 of the incoming window, or n+1 of the held one.
    always_comb begin
        src_win = req_hs ? bf_req_data : win_q;
        nxt_pos = req_hs ? 4'd0 : pos_q + 4'd1;
    end

    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_lane
        bicubic_upsample_mc_lane #(.CW(CW)) u_lane (
            .win_i (src_win[ch*16*CW +: 16*CW]),
            .pos_i (nxt_pos),
            .pix_o (nxt_pix[ch*CW +: CW])
        );
    end

    // IDLE/OUT control, window latch and registered output pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            pos_q   <= 4'd0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (req_hs) begin
            state_q <= ST_OUT;
            win_q   <= bf_req_data;
            pos_q   <= 4'd0;
            last_q  <= 1'b0;
            data_q  <= nxt_pix;
        end else if (rsp_hs) begin
            if (last_q) begin
                state_q <= ST_IDLE;
                last_q  <= 1'b0;
            end else begin
                pos_q   <= nxt_pos;
                last_q  <= (pos_q == 4'd14);
                data_q  <= nxt_pix;
            end
        end
    end
endmodule
